// File: rtl/i2c_imu_pkg.sv
// Shared types and constants for the MPU-6050 style I2C target.
//   state_e   : protocol engine states
//   REG_*     : register addresses served by the target
//   BURST_LEN : length of the sensor burst starting at REG_ACCEL_XOUT_H
//   map_byte  : read-side register map lookup
package i2c_imu_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StRegPtr,
    StPtrAck,
    StWdata,
    StWdataAck,
    StRdata,
    StMack,
    StIgnore
  } state_e;

  localparam logic [7:0] REG_ACCEL_XOUT_H = 8'h3B;
  localparam logic [7:0] REG_PWR_MGMT_1   = 8'h6B;
  localparam logic [7:0] REG_WHO_AM_I     = 8'h75;
  localparam int unsigned BURST_LEN       = 14;

  // words = {accel_x, accel_y, accel_z, temp, gyro_x, gyro_y, gyro_z}, high byte first.
  function automatic logic [7:0] map_byte(input logic [7:0]   ptr,
                                          input logic [111:0] words,
                                          input logic [7:0]   pwr,
                                          input logic [7:0]   who);
    int unsigned off;
    map_byte = 8'h00;
    // Pointers below the burst base wrap to a huge offset and fall out of range.
    off = 32'(ptr) - 32'(REG_ACCEL_XOUT_H);
    if (off < BURST_LEN) begin
      map_byte = 8'(words >> (8 * (BURST_LEN - 1 - off)));
    end else if (ptr == REG_PWR_MGMT_1) begin
      map_byte = pwr;
    end else if (ptr == REG_WHO_AM_I) begin
      map_byte = who;
    end
  endfunction

endpackage

// File: rtl/i2c_imu_target_bus_cond.sv
// I2C bus conditioning: 2-flop synchronizer and 3-sample majority filter on SCL and SDA,
// followed by edge and START/STOP detection on the filtered levels.
//   clk, reset         : system clock, asynchronous active-high reset
//   scl_in, sda_in     : raw pad inputs
//   sda_filt           : filtered SDA level
//   scl_rise, scl_fall : one-cycle strobes on filtered SCL edges
//   start_det          : SDA falling while SCL high
//   stop_det           : SDA rising while SCL high
// Pad-to-strobe latency is 3 clk, so the engine acts on the 4th clk edge.
module i2c_bus_cond
  import i2c_imu_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda_filt,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  // Bit 0 carries SCL, bit 1 carries SDA.
  logic [1:0] meta_q, sync_q, hist0_q, hist1_q, filt_q;
  logic [1:0] filt;

  // Reset to the idle-bus level so releasing reset never fakes an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q  <= 2'b11;
      sync_q  <= 2'b11;
      hist0_q <= 2'b11;
      hist1_q <= 2'b11;
      filt_q  <= 2'b11;
    end else begin
      meta_q  <= {sda_in, scl_in};
      sync_q  <= meta_q;
      hist0_q <= sync_q;
      hist1_q <= hist0_q;
      filt_q  <= filt;
    end
  end

  assign filt = (sync_q & hist0_q) | (sync_q & hist1_q) | (hist0_q & hist1_q);

  assign sda_filt  = filt[1];
  assign scl_rise  = filt[0] & ~filt_q[0];
  assign scl_fall  = ~filt[0] & filt_q[0];
  // SCL must be high both before and after the SDA transition.
  assign start_det = ~filt[1] & filt_q[1] & filt[0] & filt_q[0];
  assign stop_det  = filt[1] & ~filt_q[1] & filt[0] & filt_q[0];

endmodule

// File: rtl/i2c_imu_target.sv
// I2C target emulating the MPU-6050 register interface: 14-byte sensor burst at 0x3B..0x48,
// WHO_AM_I at 0x75 and a writable PWR_MGMT_1 at 0x6B. SDA is open-drain (pull-low only);
// SCL is never stretched.
//   clk, reset       : system clock (>= 16x SCL), asynchronous active-high reset
//   scl_in, sda_in   : raw pad inputs
//   sda_oe           : 1 pulls SDA low
//   accel_*, temp,
//   gyro_*           : sensor words served by the burst
//   pwr_mgmt         : current PWR_MGMT_1 value
//   busy             : high from START until STOP
//   rd_done          : one-cycle pulse when the master NACKs a read byte
// Build option IMU_SNAPSHOT_EN: latch all sensor words on a read address match so the whole
// burst is coherent; otherwise each byte is taken live when it is loaded.
module i2c_imu_target
  import i2c_imu_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR     = 7'h68,
  parameter logic [7:0] WHO_AM_I_VAL = 8'h68,
  parameter logic [7:0] PWR_MGMT_RST = 8'h40
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_oe,
  input  logic [15:0] accel_x,
  input  logic [15:0] accel_y,
  input  logic [15:0] accel_z,
  input  logic [15:0] temp,
  input  logic [15:0] gyro_x,
  input  logic [15:0] gyro_y,
  input  logic [15:0] gyro_z,
  output logic [7:0]  pwr_mgmt,
  output logic        busy,
  output logic        rd_done
);

  logic sda_filt, scl_rise, scl_fall, start_det, stop_det;

  i2c_bus_cond u_bus_cond (
    .clk       (clk),
    .reset     (reset),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .sda_filt  (sda_filt),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  state_e      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  // ACK slot sub-phase: 0 = before the 9th SCL low, 1 = slot driven/released,
  // 2 = master ACKed a read byte, next byte loads on the coming fall.
  logic [1:0]  ack_phase_q, ack_phase_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        rw_q, rw_d;
  logic [7:0]  reg_ptr_q, reg_ptr_d;
  logic [7:0]  pwr_q, pwr_d;
  logic        sda_oe_q, sda_oe_d;
  logic        busy_q, busy_d;
  logic        rd_done_q, rd_done_d;

  logic [7:0]   rx_byte;
  logic [7:0]   rd_byte;
  logic [111:0] words_live, words;

  assign words_live = {accel_x, accel_y, accel_z, temp, gyro_x, gyro_y, gyro_z};
  assign rx_byte    = {shreg_q[6:0], sda_filt};

`ifdef IMU_SNAPSHOT_EN
  logic [111:0] snap_q;
  logic         addr_rd_match;

  assign addr_rd_match = (state_q == StAddr) && scl_rise && !start_det && !stop_det &&
                         (bit_cnt_q == 3'd7) && (rx_byte == {DEV_ADDR, 1'b1});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap_q <= '0;
    end else if (addr_rd_match) begin
      snap_q <= words_live;
    end
  end

  assign words = snap_q;
`else
  assign words = words_live;
`endif

  assign rd_byte = map_byte(reg_ptr_q, words, pwr_q, WHO_AM_I_VAL);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      bit_cnt_q   <= 3'd0;
      ack_phase_q <= 2'd0;
      shreg_q     <= 8'h00;
      rw_q        <= 1'b0;
      reg_ptr_q   <= 8'h00;
      pwr_q       <= PWR_MGMT_RST;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      rd_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      ack_phase_q <= ack_phase_d;
      shreg_q     <= shreg_d;
      rw_q        <= rw_d;
      reg_ptr_q   <= reg_ptr_d;
      pwr_q       <= pwr_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      rd_done_q   <= rd_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    ack_phase_d = ack_phase_q;
    shreg_d     = shreg_q;
    rw_d        = rw_q;
    reg_ptr_d   = reg_ptr_q;
    pwr_d       = pwr_q;
    sda_oe_d    = sda_oe_q;
    busy_d      = busy_q;
    rd_done_d   = 1'b0;

    if (start_det) begin
      state_d     = StAddr;
      busy_d      = 1'b1;
      sda_oe_d    = 1'b0;
      bit_cnt_d   = 3'd0;
      ack_phase_d = 2'd0;
    end else if (stop_det) begin
      state_d  = StIdle;
      busy_d   = 1'b0;
      sda_oe_d = 1'b0;
    end else begin
      unique case (state_q)
        StAddr: begin
          if (scl_rise) begin
            shreg_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              ack_phase_d = 2'd0;
              if (rx_byte[7:1] == DEV_ADDR) begin
                state_d = StAddrAck;
                rw_d    = rx_byte[0];
              end else begin
                state_d = StIgnore;
              end
            end
          end
        end
        StRegPtr: begin
          if (scl_rise) begin
            shreg_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              ack_phase_d = 2'd0;
              reg_ptr_d   = rx_byte;
              state_d     = StPtrAck;
            end
          end
        end
        StWdata: begin
          if (scl_rise) begin
            shreg_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              ack_phase_d = 2'd0;
              state_d     = StWdataAck;
              if (reg_ptr_q == REG_PWR_MGMT_1) begin
                pwr_d = rx_byte;
              end
            end
          end
        end
        StAddrAck, StPtrAck, StWdataAck: begin
          if (scl_fall) begin
            if (ack_phase_q == 2'd0) begin
              sda_oe_d    = 1'b1;
              ack_phase_d = 2'd1;
            end else begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 3'd0;
              if (state_q == StAddrAck && rw_q) begin
                // Load the first read byte; a 0 MSB keeps SDA low straight through.
                state_d  = StRdata;
                shreg_d  = rd_byte;
                sda_oe_d = ~rd_byte[7];
              end else if (state_q == StAddrAck) begin
                state_d = StRegPtr;
              end else begin
                state_d = StWdata;
                if (state_q == StWdataAck) begin
                  reg_ptr_d = reg_ptr_q + 8'd1;
                end
              end
            end
          end
        end
        StRdata: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_d     = StMack;
              ack_phase_d = 2'd0;
            end
          end else if (scl_fall) begin
            shreg_d  = {shreg_q[6:0], 1'b0};
            sda_oe_d = ~shreg_q[6];
          end
        end
        StMack: begin
          if (scl_fall && ack_phase_q == 2'd0) begin
            sda_oe_d    = 1'b0;
            ack_phase_d = 2'd1;
          end else if (scl_rise && ack_phase_q == 2'd1) begin
            reg_ptr_d = reg_ptr_q + 8'd1;
            if (sda_filt) begin
              rd_done_d = 1'b1;
              state_d   = StIgnore;
            end else begin
              ack_phase_d = 2'd2;
            end
          end else if (scl_fall && ack_phase_q == 2'd2) begin
            state_d   = StRdata;
            bit_cnt_d = 3'd0;
            shreg_d   = rd_byte;
            sda_oe_d  = ~rd_byte[7];
          end
        end
        StIdle, StIgnore: begin
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  assign sda_oe   = sda_oe_q;
  assign pwr_mgmt = pwr_q;
  assign busy     = busy_q;
  assign rd_done  = rd_done_q;

endmodule

// File: tb/tb_i2c_imu_target.sv
// Bench for i2c_imu_target: a bit-banged I2C master on a wired-AND SDA line, a register-map
// model of the target, and a per-cycle compare process for busy / pwr_mgmt / released SDA.
module tb_i2c_imu_target;

  localparam int Q = 10;  // clk cycles per quarter SCL period

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        scl_m = 1'b1;
  logic        sda_m = 1'b1;
  logic        sda_line;
  logic        sda_oe;
  logic [15:0] accel_x = 16'h1234, accel_y = 16'h5678, accel_z = 16'h9ABC, temp = 16'hDEF0;
  logic [15:0] gyro_x = 16'h1357, gyro_y = 16'h2468, gyro_z = 16'hCDEF;
  logic [7:0]  pwr_mgmt;
  logic        busy;
  logic        rd_done;

  assign sda_line = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_imu_target dut (
    .clk      (clk),
    .reset    (reset),
    .scl_in   (scl_m),
    .sda_in   (sda_line),
    .sda_oe   (sda_oe),
    .accel_x  (accel_x),
    .accel_y  (accel_y),
    .accel_z  (accel_z),
    .temp     (temp),
    .gyro_x   (gyro_x),
    .gyro_y   (gyro_y),
    .gyro_z   (gyro_z),
    .pwr_mgmt (pwr_mgmt),
    .busy     (busy),
    .rd_done  (rd_done)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  // Model state
  logic [7:0] m_pwr = 8'h40;
  logic [7:0] m_ptr = 8'h00;
  logic       m_busy = 1'b0;
  logic       m_release = 1'b0;
  logic       chk_en = 1'b0;
  int         m_nacks = 0;
  int         rd_done_cnt = 0;
`ifdef IMU_SNAPSHOT_EN
  logic [15:0] snap_w [7];
`endif

  function automatic logic [7:0] model_byte(input logic [7:0] ptr);
    logic [15:0] w [7];
    int k;
`ifdef IMU_SNAPSHOT_EN
    for (int i = 0; i < 7; i++) w[i] = snap_w[i];
`else
    w[0] = accel_x; w[1] = accel_y; w[2] = accel_z; w[3] = temp;
    w[4] = gyro_x;  w[5] = gyro_y;  w[6] = gyro_z;
`endif
    k = int'(ptr) - 'h3B;
    if (k >= 0 && k < 14) model_byte = (k % 2 == 1) ? w[k / 2][7:0] : w[k / 2][15:8];
    else if (ptr == 8'h6B) model_byte = m_pwr;
    else if (ptr == 8'h75) model_byte = 8'h68;
    else model_byte = 8'h00;
  endfunction

  always @(negedge clk) if (rd_done === 1'b1) rd_done_cnt++;

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", int'(busy), int'(m_busy));
      check("pwr_mgmt", int'(pwr_mgmt), int'(m_pwr));
      if (m_release) check("sda_released", int'(sda_oe), 0);
    end
  end

  task automatic wq(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    chk_en = 1'b0; m_release = 1'b0;
    sda_m = 1'b1; wq(Q); scl_m = 1'b1; wq(Q); sda_m = 1'b0; wq(Q); scl_m = 1'b0; wq(Q);
    m_busy = 1'b1; chk_en = 1'b1;
  endtask

  task automatic bus_stop();
    chk_en = 1'b0;
    sda_m = 1'b0; wq(Q); scl_m = 1'b1; wq(Q); sda_m = 1'b1; wq(Q);
    m_busy = 1'b0; m_release = 1'b1; chk_en = 1'b1; wq(Q);
  endtask

  task automatic bit_xfer(input logic b, output logic s);
    sda_m = b; wq(Q); scl_m = 1'b1; wq(Q); s = sda_line; wq(Q); scl_m = 1'b0; wq(Q);
  endtask

  task automatic wr_byte(input logic [7:0] v, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_xfer(v[i], s);
`ifdef IMU_SNAPSHOT_EN
    if (v == 8'hD1) begin
      snap_w[0] = accel_x; snap_w[1] = accel_y; snap_w[2] = accel_z; snap_w[3] = temp;
      snap_w[4] = gyro_x;  snap_w[5] = gyro_y;  snap_w[6] = gyro_z;
    end
`endif
    bit_xfer(1'b1, ack);
  endtask

  task automatic wr_acked(input string name, input logic [7:0] v);
    logic ack;
    wr_byte(v, ack);
    check(name, int'(ack), 0);
  endtask

  task automatic set_ptr(input logic [7:0] p);
    bus_start(); wr_acked("ack_addr_w", 8'hD0); wr_acked("ack_ptr", p); m_ptr = p;
  endtask

  task automatic rd_bits(output logic [7:0] v);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, s);
      v[i] = s;
    end
  endtask

  // Reads one byte, checks it against the model, then sends ACK (nack=0) or NACK.
  task automatic read_chk(input logic nack, output logic [7:0] v);
    logic [7:0] exp;
    logic s;
    exp = model_byte(m_ptr);
    rd_bits(v);
    check("rd_byte_model", int'(v), int'(exp));
    bit_xfer(nack, s);
    m_ptr = m_ptr + 8'd1;
    if (nack) m_nacks++;
  endtask

  logic [7:0] lit [14] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0,
                           8'h13, 8'h57, 8'h24, 8'h68, 8'hCD, 8'hEF};

  initial begin
    logic [7:0] v;
    logic ack, s;

    // Reset values
    wq(4);
    check("rst_sda_oe", int'(sda_oe), 0);
    check("rst_pwr_mgmt", int'(pwr_mgmt), 'h40);
    check("rst_busy", int'(busy), 0);
    check("rst_rd_done", int'(rd_done), 0);
    reset = 1'b0;
    wq(4);
    chk_en = 1'b1; m_release = 1'b1;

    // Full burst: pointer 0x3B, repeated START, 14 bytes, NACK the last
    set_ptr(8'h3B);
    bus_start(); wr_acked("ack_addr_r", 8'hD1);
    for (int i = 0; i < 14; i++) begin
      read_chk(i == 13, v);
      check($sformatf("burst_lit%0d", i), int'(v), int'(lit[i]));
    end
    bus_stop();
    check("rd_done_burst", rd_done_cnt, 1);

    // Wrong address: never pulls SDA, busy until STOP
    bus_start(); m_release = 1'b1;
    wr_byte(8'hD2, ack);
    check("nak_addr_0x69", int'(ack), 1);
    check("busy_ignored", int'(busy), 1);
    wr_byte(8'h3B, ack);
    check("nak_ignored_data", int'(ack), 1);
    bus_stop();
    check("busy_after_stop", int'(busy), 0);

    // PWR_MGMT_1 write then read back
    set_ptr(8'h6B);
    chk_en = 1'b0;
    wr_byte(8'h01, ack);
    check("ack_wdata", int'(ack), 0);
    m_pwr = 8'h01; m_ptr = m_ptr + 8'd1; chk_en = 1'b1;
    check("pwr_after_write", int'(pwr_mgmt), 'h01);
    bus_start(); wr_acked("ack_addr_w", 8'hD0); wr_acked("ack_ptr", 8'h6B); m_ptr = 8'h6B;
    bus_start(); wr_acked("ack_addr_r", 8'hD1);
    read_chk(1'b1, v);
    check("pwr_readback", int'(v), 'h01);
    bus_stop();

    // Reset during the 5th data bit of a read of 0x01 (bit 3 = 0, so SDA is held low)
    set_ptr(8'h6B);
    bus_start(); wr_acked("ack_addr_r", 8'hD1);
    for (int i = 0; i < 4; i++) bit_xfer(1'b1, s);
    sda_m = 1'b1; wq(Q);
    check("pre_reset_drive", int'(sda_oe), 1);
    scl_m = 1'b1; wq(Q / 2);
    chk_en = 1'b0;
    #1 reset = 1'b1;
    #1;
    check("reset_sda_oe", int'(sda_oe), 0);
    check("reset_pwr_mgmt", int'(pwr_mgmt), 'h40);
    check("reset_busy", int'(busy), 0);
    wq(3);
    reset = 1'b0;
    m_pwr = 8'h40; m_ptr = 8'h00; m_busy = 1'b0;
    wq(Q); scl_m = 1'b0; wq(Q);
    bus_stop();

    // WHO_AM_I, then pointer wrap 0xFF -> 0x00
    set_ptr(8'h75);
    bus_start(); wr_acked("ack_addr_r", 8'hD1);
    read_chk(1'b1, v);
    check("who_am_i", int'(v), 'h68);
    bus_stop();
    set_ptr(8'hFF);
    bus_start(); wr_acked("ack_addr_r", 8'hD1);
    read_chk(1'b0, v);
    check("ptr_ff", int'(v), 'h00);
    read_chk(1'b1, v);
    check("ptr_wrap_00", int'(v), 'h00);
    check("model_ptr_wrapped", int'(m_ptr), 'h01);
    bus_stop();

    // accel_x changes after the first byte of the burst
    set_ptr(8'h3B);
    bus_start(); wr_acked("ack_addr_r", 8'hD1);
    rd_bits(v);
    check("snap_b0_model", int'(v), int'(model_byte(m_ptr)));
    check("snap_b0_lit", int'(v), 'h12);
    accel_x = 16'h5678;
    bit_xfer(1'b0, s);
    m_ptr = m_ptr + 8'd1;
    read_chk(1'b1, v);
`ifdef IMU_SNAPSHOT_EN
    check("snap_b1_lit", int'(v), 'h34);
`else
    check("live_b1_lit", int'(v), 'h78);
`endif
    bus_stop();

    check("rd_done_total", rd_done_cnt, m_nacks);
    check("rd_done_nacks", m_nacks, 5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
